// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch front end with a valid/ready
//            hand-off to decode and PC redirect handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [CNT_W-1:0]   fetch_count,
    output logic               protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic [CNT_W-1:0]   r_fetch_count;
    logic               r_protocol_err;
    logic               w_capture;
    logic               w_accept;
    logic               w_stray;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_DROP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response coinciding with a redirect is stale: refetch at once.
                if (redirect_valid && imem_rvalid) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_DROP;
                end else if (imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_REQ;
                end else if (instr_ready) begin
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_target;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Responses are only legal while a request is outstanding (WAIT or DROP).
    assign w_stray = imem_rvalid &&
                     (r_state == S_IDLE || r_state == S_REQ || r_state == S_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_instr        <= '0;
            r_instr_pc     <= '0;
            r_fetch_count  <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
            if (w_stray) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign imem_req     = (r_state == S_REQ);
    assign imem_addr    = r_pc;
    assign instr_valid  = (r_state == S_HOLD);
    assign instr        = r_instr;
    assign op           = r_instr[INSTR_W-1 -: 6];
    assign instr_pc     = r_instr_pc;
    assign fetch_count  = r_fetch_count;
    assign protocol_err = r_protocol_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [8:0]  imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [8:0]  instr;
    logic [5:0]  op;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [15:0] fetch_count;
    logic        protocol_err;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (9),
        .RESET_PC (8'h00),
        .CNT_W    (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .op              (op),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_count     (fetch_count),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        tick(); tick();
        checks++; if ({imem_req, instr_valid, protocol_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {imem_req, instr_valid, protocol_err}); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
        checks++; if (instr !== 9'h000 || instr_pc !== 8'h00) begin errors++; $display("FAIL reset_instr got %h/%h want 000/00", instr, instr_pc); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL first_req got req=%b addr=%h want 1/00", imem_req, imem_addr); end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait1 got req=%b valid=%b want 0/0", imem_req, instr_valid); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 9'h0A8;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", instr_valid); end
        checks++; if (instr !== 9'h0A8 || op !== 6'h15) begin errors++; $display("FAIL first_instr got %h op %h want 0a8 op 15", instr, op); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL first_pc got %h want 00", instr_pc); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr !== 9'h0A8 || op !== 6'h15 || instr_pc !== 8'h00 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d got instr=%h op=%h pc=%h req=%b valid=%b want 0a8/15/00/0/1", i, instr, op, instr_pc, imem_req, instr_valid);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL accept_count got %0d want 1", fetch_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin errors++; $display("FAIL accept_next got req=%b addr=%h want 1/01", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_valid = 1'b0; redirect_target = '0;
        checks++; if (imem_addr !== 8'h40 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL drop_state got addr=%h req=%b valid=%b want 40/0/0", imem_addr, imem_req, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait got valid=%b req=%b want 0/0", instr_valid, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 9'h1FF;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin errors++; $display("FAIL refetch got req=%b addr=%h valid=%b want 1/40/0", imem_req, imem_addr, instr_valid); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL drop_no_err got %b want 0", protocol_err); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 9'h123;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (instr_valid !== 1'b1 || instr !== 9'h123 || op !== 6'h24) begin errors++; $display("FAIL redir_instr got valid=%b instr=%h op=%h want 1/123/24", instr_valid, instr, op); end
        checks++; if (instr_pc !== 8'h40) begin errors++; $display("FAIL redir_pc got %h want 40", instr_pc); end
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1; redirect_target = 8'h10; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin errors++; $display("FAIL hold_redir got req=%b addr=%h want 1/10", imem_req, imem_addr); end
        checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL hold_redir_count got %0d want 1", fetch_count); end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_target = 8'hFF;
        tick();
        redirect_valid = 1'b0; redirect_target = '0;
        checks++; if (imem_addr !== 8'hFF || imem_req !== 1'b0) begin errors++; $display("FAIL req_redir got addr=%h req=%b want ff/0", imem_addr, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 9'h0AA;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_req got req=%b addr=%h want 1/ff", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 9'h0F0;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (instr_valid !== 1'b1 || instr !== 9'h0F0 || instr_pc !== 8'hFF) begin errors++; $display("FAIL wrap_hold got valid=%b instr=%h pc=%h want 1/0f0/ff", instr_valid, instr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr got addr=%h req=%b want 00/1", imem_addr, imem_req); end
        checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", fetch_count); end
    endtask

    task automatic test_protocol_err();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 9'h055;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (instr_valid !== 1'b1 || instr !== 9'h055 || protocol_err !== 1'b0) begin errors++; $display("FAIL perr_pre got valid=%b instr=%h err=%b want 1/055/0", instr_valid, instr, protocol_err); end
        imem_rvalid = 1'b1; imem_rdata = 9'h1AA;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set got %b want 1", protocol_err); end
        checks++; if (instr !== 9'h055 || instr_valid !== 1'b1) begin errors++; $display("FAIL perr_instr got instr=%h valid=%b want 055/1", instr, instr_valid); end
        tick(); tick();
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b want 1", protocol_err); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (fetch_count !== 16'd3 || imem_addr !== 8'h01 || protocol_err !== 1'b1) begin errors++; $display("FAIL perr_accept got cnt=%0d addr=%h err=%b want 3/01/1", fetch_count, imem_addr, protocol_err); end
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({imem_req, instr_valid, protocol_err} !== 3'b000) begin errors++; $display("FAIL async_flags got %b want 000", {imem_req, instr_valid, protocol_err}); end
        checks++; if (imem_addr !== 8'h00 || instr !== 9'h000 || instr_pc !== 8'h00) begin errors++; $display("FAIL async_data got addr=%h instr=%h pc=%h want 00/000/00", imem_addr, instr, instr_pc); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL async_count got %0d want 0", fetch_count); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || protocol_err !== 1'b0) begin errors++; $display("FAIL post_reset got req=%b addr=%h err=%b want 1/00/0", imem_req, imem_addr, protocol_err); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_pc_wrap();
        test_protocol_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
